sample_reader: RTL and testbench

SAMPLE_READER -- requirements
Module: sample_reader

---
 rtl/sample_reader.sv | 165 ++++++++++++++++
 tb/tb_sample_reader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sample_reader.sv
// Snapshot a packed bank of N samples on start, then stream them out one per
// valid/ready handshake while accumulating their sum; done pulses at pass end.
module sample_reader #(
    parameter int DATA_WIDTH = 12,
    parameter int N          = 14,
    parameter int IDX_W      = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [N*DATA_WIDTH-1:0]     in_smpls,
    output logic [DATA_WIDTH-1:0]       out_smpl,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done,
    output logic [DATA_WIDTH+IDX_W-1:0] sum
);

    localparam int SW = DATA_WIDTH + IDX_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_bank [N];
    logic [SW-1:0]         r_acc;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_smpl;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_done;
    logic [SW-1:0]         r_sum;

    logic                  w_load;
    logic                  w_last;
    logic [IDX_W-1:0]      w_idx_inc;
    logic [SW-1:0]         w_acc_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [DATA_WIDTH-1:0] w_smpl_nxt;
    logic                  w_valid_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic [SW-1:0]         w_sum_nxt;

    assign w_last    = (r_idx == IDX_W'(N - 1));
    assign w_idx_inc = r_idx + IDX_W'(1);

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_acc_nxt   = r_acc;
        w_idx_nxt   = r_idx;
        w_smpl_nxt  = r_smpl;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_sum_nxt   = r_sum;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = SEND;
                    w_load      = 1'b1;
                    w_acc_nxt   = {SW{1'b0}};
                    w_idx_nxt   = {IDX_W{1'b0}};
                    w_smpl_nxt  = in_smpls[DATA_WIDTH-1:0];
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                end
            end
            SEND: begin
                if (out_ready) begin
                    // The sample leaving on this edge is counted in the same edge
                    w_acc_nxt = r_acc + {{IDX_W{1'b0}}, r_smpl};
                    if (w_last) begin
                        w_state_nxt = DONE;
                        w_valid_nxt = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_sum_nxt   = w_acc_nxt;
                    end else begin
                        w_idx_nxt  = w_idx_inc;
                        w_smpl_nxt = r_bank[w_idx_inc];
                    end
                end else begin
                    w_state_nxt = SEND;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = {IDX_W{1'b0}};
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = {IDX_W{1'b0}};
                w_valid_nxt = 1'b0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Registered datapath and status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc   <= {SW{1'b0}};
            r_idx   <= {IDX_W{1'b0}};
            r_smpl  <= {DATA_WIDTH{1'b0}};
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= {SW{1'b0}};
        end else begin
            r_acc   <= w_acc_nxt;
            r_idx   <= w_idx_nxt;
            r_smpl  <= w_smpl_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_sum   <= w_sum_nxt;
        end
    end

    // Snapshot bank, captured only when a pass is accepted
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                r_bank[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (w_load) begin
            for (int i = 0; i < N; i++) begin
                r_bank[i] <= in_smpls[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                r_bank[i] <= r_bank[i];
            end
        end
    end

    assign out_smpl  = r_smpl;
    assign out_idx   = r_idx;
    assign out_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sum       = r_sum;

endmodule

// File: tb/tb_sample_reader.sv
// Directed sequence of readout passes with randomized data and back-pressure,
// checked against a snapshot/sum model held in the bench.
module tb_sample_reader;

    localparam int DW = 12;
    localparam int N  = 14;
    localparam int IW = 4;
    localparam int SW = DW + IW;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [N*DW-1:0] in_smpls;
    logic [DW-1:0]   out_smpl;
    logic [IW-1:0]   out_idx;
    logic            out_valid;
    logic            out_ready;
    logic            busy;
    logic            done;
    logic [SW-1:0]   sum;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW-1:0] m_snap [N];
    logic [SW-1:0] m_sum;

    sample_reader #(.DATA_WIDTH(DW), .N(N), .IDX_W(IW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_smpls (in_smpls),
        .out_smpl (out_smpl),
        .out_idx  (out_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done),
        .sum      (sum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: all 12'h400, 1: i+1, 2: all 12'hFFF, otherwise random
    task automatic set_bank(input int mode);
        for (int i = 0; i < N; i++) begin
            case (mode)
                0:       in_smpls[i*DW +: DW] = 12'h400;
                1:       in_smpls[i*DW +: DW] = DW'(i + 1);
                2:       in_smpls[i*DW +: DW] = 12'hFFF;
                default: in_smpls[i*DW +: DW] = DW'($urandom);
            endcase
        end
    endtask

    // rmode 0: ready held high, 1: ready toggles 1/0, 2: random ready
    task automatic run_pass(input int rmode, input bit disturb, input int abort_at);
        logic [SW-1:0] acc;
        logic [SW-1:0] prev_sum;
        int k;
        int cyc;
        prev_sum = m_sum;
        chk("idle_busy", 32'(busy), 32'd0);
        for (int i = 0; i < N; i++) m_snap[i] = in_smpls[i*DW +: DW];
        start = 1'b1;
        tick();
        start = 1'b0;
        k   = 0;
        cyc = 0;
        acc = '0;
        while (k < N && cyc < 20 * N) begin
            chk("valid", 32'(out_valid), 32'd1);
            chk("idx", 32'(out_idx), 32'(k));
            chk("smpl", 32'(out_smpl), 32'(m_snap[k]));
            chk("busy_send", 32'(busy), 32'd1);
            chk("done_send", 32'(done), 32'd0);
            chk("sum_hold", 32'(sum), 32'(prev_sum));
            if (abort_at == k) begin
                #2 rst = 1'b0;
                #1;
                chk("rst_valid", 32'(out_valid), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_idx", 32'(out_idx), 32'd0);
                chk("rst_smpl", 32'(out_smpl), 32'd0);
                chk("rst_sum", 32'(sum), 32'd0);
                m_sum = '0;
                tick();
                tick();
                chk("rst_no_done", 32'(done), 32'd0);
                #2 rst = 1'b1;
                tick();
                chk("post_rst_busy", 32'(busy), 32'd0);
                chk("post_rst_sum", 32'(sum), 32'd0);
                return;
            end
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (cyc % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (disturb) begin
                set_bank(3);
                start = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
            if (out_ready) begin
                acc = acc + SW'(m_snap[k]);
                k++;
            end
        end
        chk("pass_progress", 32'(k), 32'(N));
        start = disturb;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_valid", 32'(out_valid), 32'd0);
        chk("done_busy", 32'(busy), 32'd1);
        chk("done_sum", 32'(sum), 32'(acc));
        chk("done_smpl_hold", 32'(out_smpl), 32'(m_snap[N-1]));
        if (rmode == 0) chk("latency", 32'(cyc), 32'(N));
        m_sum = acc;
        tick();
        start = 1'b0;
        chk("after_done", 32'(done), 32'd0);
        chk("after_busy", 32'(busy), 32'd0);
        chk("after_idx", 32'(out_idx), 32'd0);
        chk("after_valid", 32'(out_valid), 32'd0);
        chk("after_sum", 32'(sum), 32'(m_sum));
        chk("after_smpl", 32'(out_smpl), 32'(m_snap[N-1]));
        tick();
        chk("no_requeue_busy", 32'(busy), 32'd0);
        chk("no_requeue_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        in_smpls  = '0;
        m_sum     = '0;
        tick();
        chk("reset_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_idx", 32'(out_idx), 32'd0);
        chk("reset_smpl", 32'(out_smpl), 32'd0);
        chk("reset_sum", 32'(sum), 32'd0);
        #2 rst = 1'b1;
        tick();

        set_bank(0);
        run_pass(0, 1'b0, -1);
        chk("sum_all_400", 32'(sum), 32'h3800);

        set_bank(1);
        run_pass(1, 1'b0, -1);
        chk("sum_ramp", 32'(sum), 32'd105);

        set_bank(2);
        run_pass(0, 1'b0, -1);
        chk("sum_all_fff", 32'(sum), 32'd57330);
        tick();
        tick();
        chk("sum_held_idle", 32'(sum), 32'd57330);

        set_bank(3);
        run_pass(2, 1'b1, -1);

        for (int p = 0; p < 4; p++) begin
            set_bank(3);
            run_pass(p % 3, 1'b0, -1);
        end

        set_bank(3);
        run_pass(0, 1'b0, 6);
        set_bank(3);
        run_pass(0, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
